// File: rtl/nasti_lite_byte_master.sv
// Byte-stream to NASTI-Lite bridge: 57/52 command bytes become single write/read
// transactions, and the status byte (plus read data) is returned on the tx stream.
module nasti_lite_byte_master #(
  parameter logic [7:0] RESP_OK_BYTE  = 8'h4B,
  parameter logic [7:0] RESP_ERR_BYTE = 8'h45
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] aw_addr,
  output logic       aw_valid,
  input  logic       aw_ready,
  output logic [7:0] w_data,
  output logic       w_strb,
  output logic       w_valid,
  input  logic       w_ready,
  input  logic [1:0] b_resp,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] ar_addr,
  output logic       ar_valid,
  input  logic       ar_ready,
  input  logic [7:0] r_data,
  input  logic [1:0] r_resp,
  input  logic       r_valid,
  output logic       r_ready
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_SEND_STAT,
    S_SEND_DATA
  } state_t;

  state_t     state, state_nxt;
  logic       op_wr;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic [7:0] status_q;
  logic       aw_pend;
  logic       w_pend;

  logic rx_acc;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;
  logic aw_done;
  logic w_done;

  function automatic logic [7:0] resp_to_status(input logic [1:0] resp);
    return (resp == 2'b00) ? RESP_OK_BYTE : RESP_ERR_BYTE;
  endfunction

  // Every output is a pure decode of registered state.
  assign rx_ready = (state == S_IDLE) || (state == S_GET_ADDR) || (state == S_GET_DATA);
  assign aw_valid = (state == S_WR_REQ) && aw_pend;
  assign w_valid  = (state == S_WR_REQ) && w_pend;
  assign aw_addr  = addr_q;
  assign w_data   = wdata_q;
  assign w_strb   = 1'b1;
  assign b_ready  = (state == S_WR_RESP);
  assign ar_valid = (state == S_RD_REQ);
  assign ar_addr  = addr_q;
  assign r_ready  = (state == S_RD_RESP);
  assign tx_valid = (state == S_SEND_STAT) || (state == S_SEND_DATA);
  assign tx_data  = (state == S_SEND_DATA) ? rdata_q : status_q;

  assign rx_acc  = rx_valid && rx_ready;
  assign aw_hs   = aw_valid && aw_ready;
  assign w_hs    = w_valid && w_ready;
  assign b_hs    = b_valid && b_ready;
  assign r_hs    = r_valid && r_ready;
  // A channel counts as done if it handshook earlier or is handshaking now.
  assign aw_done = !aw_pend || aw_ready;
  assign w_done  = !w_pend || w_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (rx_acc && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)))
          state_nxt = S_GET_ADDR;
      S_GET_ADDR:
        if (rx_acc) state_nxt = op_wr ? S_GET_DATA : S_RD_REQ;
      S_GET_DATA:
        if (rx_acc) state_nxt = S_WR_REQ;
      S_WR_REQ:
        if (aw_done && w_done) state_nxt = S_WR_RESP;
      S_WR_RESP:
        if (b_valid) state_nxt = S_SEND_STAT;
      S_RD_REQ:
        if (ar_ready) state_nxt = S_RD_RESP;
      S_RD_RESP:
        if (r_valid) state_nxt = S_SEND_STAT;
      S_SEND_STAT:
        if (tx_ready) state_nxt = op_wr ? S_IDLE : S_SEND_DATA;
      S_SEND_DATA:
        if (tx_ready) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_wr    <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      status_q <= 8'h00;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
    end else begin
      if (state == S_IDLE && rx_acc)
        op_wr <= (rx_data == CMD_WRITE);
      if (state == S_GET_ADDR && rx_acc)
        addr_q <= rx_data;
      // Both write channels arm together so AW and W rise on the same cycle.
      if (state == S_GET_DATA && rx_acc) begin
        wdata_q <= rx_data;
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else begin
        if (aw_hs) aw_pend <= 1'b0;
        if (w_hs)  w_pend  <= 1'b0;
      end
      if (b_hs)
        status_q <= resp_to_status(b_resp);
      if (r_hs) begin
        status_q <= resp_to_status(r_resp);
        rdata_q  <= r_data;
      end
    end
  end

endmodule

// File: tb/tb_nasti_lite_byte_master.sv
// Scoreboard bench for nasti_lite_byte_master: randomized slave readiness and
// responses, expected AXI and tx traffic queued per command.
module tb_nasti_lite_byte_master;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] aw_addr;
  logic       aw_valid;
  logic       aw_ready = 1'b0;
  logic [7:0] w_data;
  logic       w_strb;
  logic       w_valid;
  logic       w_ready = 1'b0;
  logic [1:0] b_resp = 2'b00;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] ar_addr;
  logic       ar_valid;
  logic       ar_ready = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic [1:0] r_resp = 2'b00;
  logic       r_valid = 1'b0;
  logic       r_ready;

  nasti_lite_byte_master dut (
    .clk(clk), .rstn(rstn),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] aw_q[$];
  logic [7:0] w_q[$];
  logic [7:0] ar_q[$];
  logic [7:0] tx_q[$];
  logic [1:0] b_q[$];
  logic [9:0] r_q[$];

  int unsigned aw_pct = 100, w_pct = 100, ar_pct = 100, b_pct = 100, r_pct = 100, tx_pct = 100;
  bit r_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  function automatic logic [7:0] status_of(input logic [1:0] resp);
    return (resp == 2'd0) ? 8'h4B : 8'h45;
  endfunction

  // Slave drivers set inputs at negedge; monitors sample 2ns later, before the posedge.
  always @(negedge clk) begin
    aw_ready = ($urandom_range(99) < aw_pct);
    #2;
    if (rstn && aw_valid && aw_ready) begin
      if (aw_q.size() == 0) flag("aw_unexpected", aw_addr);
      else check("aw_addr", aw_addr, aw_q.pop_front());
    end
  end

  always @(negedge clk) begin
    w_ready = ($urandom_range(99) < w_pct);
    #2;
    if (rstn && w_valid && w_ready) begin
      check("w_strb", w_strb, 1);
      if (w_q.size() == 0) flag("w_unexpected", w_data);
      else check("w_data", w_data, w_q.pop_front());
    end
  end

  always @(negedge clk) begin
    ar_ready = ($urandom_range(99) < ar_pct);
    #2;
    if (rstn && ar_valid && ar_ready) begin
      if (ar_q.size() == 0) flag("ar_unexpected", ar_addr);
      else check("ar_addr", ar_addr, ar_q.pop_front());
    end
  end

  bit b_hs = 1'b0;
  always @(negedge clk) begin
    if (b_hs && b_q.size() > 0) void'(b_q.pop_front());
    b_valid = (b_q.size() > 0) && ($urandom_range(99) < b_pct);
    b_resp  = (b_q.size() > 0) ? b_q[0] : 2'd0;
    #2;
    if (b_ready && (aw_q.size() > 0 || w_q.size() > 0)) flag("b_ready_early", b_ready);
    b_hs = rstn && b_valid && b_ready;
  end

  bit r_hs = 1'b0;
  always @(negedge clk) begin
    if (r_hs && r_q.size() > 0) void'(r_q.pop_front());
    r_valid = !r_hold && (r_q.size() > 0) && ($urandom_range(99) < r_pct);
    {r_resp, r_data} = (r_q.size() > 0) ? r_q[0] : 10'd0;
    #2;
    r_hs = rstn && r_valid && r_ready;
  end

  bit         tx_pend = 1'b0;
  logic [7:0] tx_prev = 8'h00;
  always @(negedge clk) begin
    tx_ready = ($urandom_range(99) < tx_pct);
    #2;
    if (tx_pend && (!tx_valid || tx_data !== tx_prev)) flag("tx_hold", tx_data);
    if (rstn && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) flag("tx_unexpected", tx_data);
      else check("tx_data", tx_data, tx_q.pop_front());
    end
    tx_pend = rstn && tx_valid && !tx_ready;
    tx_prev = tx_data;
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, output int cycles);
    bit acc;
    cycles = 0;
    rx_data = b;
    rx_valid = 1'b1;
    do begin
      #2;
      acc = rx_ready;
      @(negedge clk);
      cycles++;
    end while (!acc && cycles < 300);
    rx_valid = 1'b0;
    if (!acc) flag("rx_accept_timeout", b);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [1:0] resp);
    int n;
    aw_q.push_back(a);
    w_q.push_back(d);
    b_q.push_back(resp);
    tx_q.push_back(status_of(resp));
    send_byte(8'h57, n);
    send_byte(a, n);
    send_byte(d, n);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] d, input logic [1:0] resp);
    int n;
    ar_q.push_back(a);
    r_q.push_back({resp, d});
    tx_q.push_back(status_of(resp));
    tx_q.push_back(d);
    send_byte(8'h52, n);
    send_byte(a, n);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((aw_q.size() + w_q.size() + ar_q.size() + tx_q.size() + b_q.size() + r_q.size()) != 0
           && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) flag({name, "_timeout"}, tx_q.size());
    @(negedge clk);
  endtask

  task automatic set_pct(input int unsigned p);
    aw_pct = p; w_pct = p; ar_pct = p; b_pct = p; r_pct = p; tx_pct = p;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [7:0] g;
    // Reset state
    repeat (2) @(negedge clk);
    #2;
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_aw_valid", aw_valid, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_ar_valid", ar_valid, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_r_ready", r_ready, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Plain write, slave always ready; first byte must go in on the first edge
    set_pct(100);
    aw_q.push_back(8'h10); w_q.push_back(8'hA5); b_q.push_back(2'd0); tx_q.push_back(8'h4B);
    send_byte(8'h57, n);
    check("first_byte_cycles", n, 1);
    send_byte(8'h10, n);
    send_byte(8'hA5, n);
    wait_idle("write_basic");

    // Plain read
    do_read(8'h20, 8'h3C, 2'd0);
    wait_idle("read_basic");

    // Write with AW ready immediately, W ready after 3 cycles, error response
    set_pct(100);
    w_pct = 0;
    do_write(8'h33, 8'h5A, 2'd2);
    repeat (3) @(negedge clk);
    w_pct = 100;
    wait_idle("write_skew");

    // Garbage byte in IDLE causes nothing
    send_byte(8'h00, n);
    for (int i = 0; i < 4; i++) begin
      #2;
      check("garbage_quiet", {rx_ready, aw_valid, w_valid, ar_valid, tx_valid}, 5'b10000);
      @(negedge clk);
    end

    // Read with tx held off for 5 cycles once the status byte is presented
    tx_pct = 0;
    do_read(8'h44, 8'hC7, 2'd0);
    k = 0;
    while (!tx_valid && k < 100) begin @(negedge clk); #2; k++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("bp_rx_ready", rx_ready, 0);
      check("bp_tx_valid", tx_valid, 1);
    end
    @(negedge clk);
    tx_pct = 100;
    wait_idle("read_backpressure");

    // Asynchronous reset while waiting for read data
    r_hold = 1'b1;
    do_read(8'h20, 8'h3C, 2'd0);
    k = 0;
    #2;
    while (!r_ready && k < 100) begin @(negedge clk); #2; k++; end
    #1 rstn = 1'b0;
    #1;
    check("arst_outputs",
          {rx_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, tx_valid}, 7'b1000000);
    tx_q.delete();
    r_q.delete();
    ar_q.delete();
    r_hold = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    do_write(8'h10, 8'hA5, 2'd0);
    wait_idle("post_reset_write");

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      set_pct($urandom_range(100, 20));
      if ($urandom_range(3) == 0) begin
        g = 8'($urandom_range(255));
        if (g == 8'h57 || g == 8'h52) g = 8'h00;
        send_byte(g, n);
      end
      if ($urandom_range(1) == 0)
        do_write(8'($urandom_range(255)), 8'($urandom_range(255)), 2'($urandom_range(3)));
      else
        do_read(8'($urandom_range(255)), 8'($urandom_range(255)), 2'($urandom_range(3)));
      wait_idle("random");
    end

    check("leftover_expectations",
          aw_q.size() + w_q.size() + ar_q.size() + tx_q.size() + b_q.size() + r_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
